// File: rtl/bk_add_arbiter.sv
// Round-robin sequencer that time-shares one registered-operand adder among NREQ requesters.
// One operation is in flight at a time; results return on a tagged valid/ready channel.
module bk_add_arbiter #(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    output logic [WIDTH-1:0]      add_a,
    output logic [WIDTH-1:0]      add_b,
    output logic                  add_cin,
    input  logic [WIDTH-1:0]      add_sum,
    input  logic                  add_cout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNTW = 3;

    state_e           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [CNTW-1:0]  lat_cnt_q, lat_cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_cin_q, add_cin_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic             any_req;
    logic [IDW-1:0]   winner;
    logic [IDW-1:0]   idx;

    // Farthest offset from rr_ptr is scanned first so the nearest valid requester wins last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && any_req) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        // NOTE: every next-state value defaults to its hold value first, so no branch can infer a latch.
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        lat_cnt_d   = lat_cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    add_a_d   = req_a[int'(winner)*WIDTH +: WIDTH];
                    add_b_d   = req_b[int'(winner)*WIDTH +: WIDTH];
                    add_cin_d = req_cin[winner];
                    id_d      = winner;
                    rr_ptr_d  = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                    lat_cnt_d = CNTW'(ADD_LAT - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end else begin
                    rsp_sum_d   = add_sum;
                    rsp_cout_d  = add_cout;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            lat_cnt_q   <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            lat_cnt_q   <= lat_cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_bk_add_arbiter.sv
// Three arbiter instances (ADD_LAT 1, 3, 4), each with its own slow-adder model, requester
// driver, round-robin reference model and response scoreboard.
module tb_bk_add_arbiter;

    localparam int W     = 16;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int NLANE = 3;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           cout;
        logic [W-1:0]   sum;
    } rsp_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    for (genvar g = 0; g < NLANE; g++) begin : lane
        localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);

        logic              rst = 1'b1;
        logic              rsp_ready = 1'b1;
        logic [NREQ-1:0]   req_valid = '0;
        logic [NREQ-1:0]   req_cin = '0;
        logic [NREQ*W-1:0] req_a = '0;
        logic [NREQ*W-1:0] req_b = '0;
        logic [NREQ-1:0]   req_ready;
        logic [W-1:0]      add_a, add_b;
        logic              add_cin;
        logic [W-1:0]      add_sum = '0;
        logic              add_cout = 1'b0;
        logic              rsp_valid, rsp_cout, busy;
        logic [IDW-1:0]    rsp_id;
        logic [W-1:0]      rsp_sum;

        // Requester side: posted[i] != taken[i] means requester i has an op waiting.
        int       posted [NREQ];
        int       taken  [NREQ];
        logic [W-1:0] op_a [NREQ];
        logic [W-1:0] op_b [NREQ];
        logic         op_cin [NREQ];

        // Reference model state and observation logs.
        bit           inflight = 1'b0;
        int           rr = 0;
        int           acc_edge = 0;
        logic [W-1:0] last_a = '0;
        logic [W-1:0] last_b = '0;
        logic         last_cin = 1'b0;
        bit           prev_rst = 1'b0;
        rsp_t         exp_q [$];
        int           grants [$];
        int           grant_edges [$];
        int           hs_edges [$];
        bit           done = 1'b0;

        bk_add_arbiter #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW), .ADD_LAT(L)) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid),
            .req_ready (req_ready),
            .req_a     (req_a),
            .req_b     (req_b),
            .req_cin   (req_cin),
            .add_a     (add_a),
            .add_b     (add_b),
            .add_cin   (add_cin),
            .add_sum   (add_sum),
            .add_cout  (add_cout),
            .rsp_valid (rsp_valid),
            .rsp_ready (rsp_ready),
            .rsp_id    (rsp_id),
            .rsp_sum   (rsp_sum),
            .rsp_cout  (rsp_cout),
            .busy      (busy)
        );

        // Adder that shows a corrupted result until L cycles after its operands change.
        initial begin : adder
            logic [2*W:0] prev_ops = '0;
            int           age = 0;
            logic [W:0]   full;
            forever begin
                @(negedge clk);
                if ({add_cin, add_a, add_b} !== prev_ops) begin
                    prev_ops = {add_cin, add_a, add_b};
                    age = 0;
                end else if (age < 16) begin
                    age++;
                end
                full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
                if (age >= L - 1) {add_cout, add_sum} = full;
                else              {add_cout, add_sum} = ~full;
            end
        end

        initial begin : engine
            forever begin
                @(posedge clk);
                for (int i = 0; i < NREQ; i++)
                    if (req_valid[i] && req_ready[i] && !rst) taken[i]++;
                #1;
                for (int i = 0; i < NREQ; i++) begin
                    req_valid[i]       = (posted[i] != taken[i]);
                    req_a[i*W +: W]    = op_a[i];
                    req_b[i*W +: W]    = op_b[i];
                    req_cin[i]         = op_cin[i];
                end
            end
        end

        initial begin : monitor
            logic [NREQ-1:0] exp_ready;
            logic [W:0]      full;
            rsp_t            got;
            int              w;
            forever begin
                @(negedge clk);
                if (prev_rst) begin
                    check($sformatf("lane%0d post-reset rsp_valid", g), rsp_valid, 0);
                    check($sformatf("lane%0d post-reset busy", g), busy, 0);
                    check($sformatf("lane%0d post-reset add_a", g), add_a, 0);
                end
                check($sformatf("lane%0d busy", g), busy, inflight);
                check($sformatf("lane%0d adder operands", g), {add_cin, add_b, add_a}, {last_cin, last_b, last_a});

                w = -1;
                if (!inflight)
                    for (int k = 0; k < NREQ; k++)
                        if (w < 0 && req_valid[(rr + k) % NREQ]) w = (rr + k) % NREQ;
                exp_ready = '0;
                if (w >= 0) exp_ready[w] = 1'b1;
                check($sformatf("lane%0d req_ready", g), req_ready, exp_ready);
                check($sformatf("lane%0d rsp_valid", g), rsp_valid, inflight && (cyc >= acc_edge + L));

                if (rsp_valid) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("lane%0d rsp with empty scoreboard", g), rsp_valid, 0);
                    end else begin
                        got = {rsp_id, rsp_cout, rsp_sum};
                        check($sformatf("lane%0d rsp id/cout/sum", g), got, exp_q[0]);
                        if (rsp_ready && !rst) begin
                            void'(exp_q.pop_front());
                            inflight = 1'b0;
                            hs_edges.push_back(cyc + 1);
                        end
                    end
                end

                if (req_ready != '0 && !rst)
                    for (int i = 0; i < NREQ; i++)
                        if (req_ready[i]) begin
                            grants.push_back(i);
                            grant_edges.push_back(cyc + 1);
                        end

                if (w >= 0 && !rst) begin
                    last_a   = req_a[w*W +: W];
                    last_b   = req_b[w*W +: W];
                    last_cin = req_cin[w];
                    full     = {1'b0, last_a} + {1'b0, last_b} + {{W{1'b0}}, last_cin};
                    exp_q.push_back('{id: IDW'(w), cout: full[W], sum: full[W-1:0]});
                    inflight = 1'b1;
                    rr       = (w + 1) % NREQ;
                    acc_edge = cyc + 1;
                end

                if (rst) begin
                    inflight = 1'b0;
                    rr       = 0;
                    last_a   = '0;
                    last_b   = '0;
                    last_cin = 1'b0;
                    exp_q.delete();
                end
                prev_rst = rst;
            end
        end

        task automatic tick();
            @(posedge clk);
            #2;
        endtask

        task automatic post(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
            op_a[r]   = a;
            op_b[r]   = b;
            op_cin[r] = c;
            posted[r]++;
        endtask

        function automatic bit all_taken();
            for (int i = 0; i < NREQ; i++)
                if (posted[i] != taken[i]) return 1'b0;
            return 1'b1;
        endfunction

        function automatic logic [W-1:0] pick();
            case ($urandom_range(0, 3))
                0:       return '1;
                1:       return '0;
                default: return W'($urandom);
            endcase
        endfunction

        task automatic wait_idle(input string what);
            int n = 0;
            tick();
            while (!(all_taken() && !busy) && n < 500) begin
                tick();
                n++;
            end
            check($sformatf("lane%0d %s drained", g, what), all_taken() && !busy, 1);
        endtask

        initial begin : stim
            int order [5] = '{0, 1, 2, 3, 0};
            int gi, hi, t0;
            repeat (3) tick();
            rst = 1'b0;

            // Fairness straight out of reset: rr pointer starts at requester 0.
            gi = grants.size();
            hi = hs_edges.size();
            post(0, 16'h1111, 16'h0101, 1'b0);
            post(1, 16'h2222, 16'h0202, 1'b1);
            post(2, 16'h8000, 16'h8000, 1'b0);
            post(3, 16'h7FFF, 16'h0001, 1'b1);
            t0 = taken[0];
            for (int n = 0; n < 50 && taken[0] == t0; n++) tick();
            post(0, 16'hABCD, 16'h1234, 1'b1);
            wait_idle("fairness");
            for (int k = 0; k < 5; k++)
                check($sformatf("lane%0d fairness grant %0d", g, k),
                      (grants.size() > gi + k) ? grants[gi + k] : -1, order[k]);
            check($sformatf("lane%0d fairness 5-op span", g),
                  (hs_edges.size() > hi + 4 && grant_edges.size() > gi) ?
                      hs_edges[hi + 4] - grant_edges[gi] + 1 : -1,
                  5 * (L + 2));

            post(2, 16'h1234, 16'h0FF1, 1'b1);
            wait_idle("single");
            post(1, 16'hFFFF, 16'h0001, 1'b0);
            wait_idle("carry wrap");
            post(3, 16'hFFFF, 16'hFFFF, 1'b1);
            wait_idle("carry full");

            // Response stalled while requester 1 waits.
            rsp_ready = 1'b0;
            post(0, pick(), pick(), 1'($urandom_range(0, 1)));
            for (int n = 0; n < 50 && !rsp_valid; n++) tick();
            gi = grants.size();
            hi = hs_edges.size();
            post(1, pick(), pick(), 1'($urandom_range(0, 1)));
            repeat (10) tick();
            rsp_ready = 1'b1;
            wait_idle("backpressure");
            check($sformatf("lane%0d backpressure grant id", g),
                  (grants.size() > gi) ? grants[gi] : -1, 1);
            check($sformatf("lane%0d backpressure grant edge", g),
                  (grant_edges.size() > gi) ? grant_edges[gi] : -1,
                  (hs_edges.size() > hi) ? hs_edges[hi] + 1 : -2);

            // Abort an op in WAIT; requester 3 re-issues alongside requester 0.
            post(3, 16'h4321, 16'h1111, 1'b0);
            t0 = taken[3];
            for (int n = 0; n < 50 && taken[3] == t0; n++) tick();
            rst = 1'b1;
            tick();
            rst = 1'b0;
            gi = grants.size();
            post(3, 16'h4321, 16'h1111, 1'b0);
            post(0, 16'h0F0F, 16'hF0F0, 1'b1);
            wait_idle("post-reset pair");
            check($sformatf("lane%0d post-reset first grant", g), (grants.size() > gi) ? grants[gi] : -1, 0);
            check($sformatf("lane%0d post-reset second grant", g), (grants.size() > gi + 1) ? grants[gi + 1] : -1, 3);

            for (int n = 0; n < 400; n++) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < NREQ; i++)
                    if (posted[i] == taken[i] && $urandom_range(0, 3) == 0)
                        post(i, pick(), pick(), 1'($urandom_range(0, 1)));
                tick();
            end
            rsp_ready = 1'b1;
            wait_idle("random drain");
            done = 1'b1;
        end
    end

    initial begin : finisher
        for (int n = 0; n < 60000; n++) begin
            @(posedge clk);
            if (lane[0].done && lane[1].done && lane[2].done) break;
        end
        check("all lanes finished", {lane[0].done, lane[1].done, lane[2].done}, 3'b111);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
